// File: rtl/pid_pkg.sv
// Shared types, width helpers and default gains for the pid_ctrl_param block.
package pid_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ERR  = 3'd1,
    MUL  = 3'd2,
    SUM  = 3'd3,
    HOLD = 3'd4
  } pid_state_e;

  // Unity, zero, zero in the default Q4.4 gain format.
  localparam logic [7:0] DEF_KP = 8'h10;
  localparam logic [7:0] DEF_KI = 8'h00;
  localparam logic [7:0] DEF_KD = 8'h00;

  // Number of bits needed to hold the unsigned value v (at least 1).
  function automatic int bits_for(input longint unsigned v);
    int n;
    n = 1;
    for (int i = 1; i < 64; i++) begin
      if ((v >> i) != 0) n = i + 1;
    end
    return n;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pid_sat.sv
// Signed clamp of din into [lo, hi] with over/under flags; width set by W.
module pid_sat #(
  parameter int W = 16
) (
  input  logic signed [W-1:0] din,
  input  logic signed [W-1:0] lo,
  input  logic signed [W-1:0] hi,
  output logic signed [W-1:0] dout,
  output logic                over,
  output logic                under
);

  always_comb begin
    dout  = din;
    over  = 1'b0;
    under = 1'b0;
    if (din > hi) begin
      dout = hi;
      over = 1'b1;
    end else if (din < lo) begin
      dout  = lo;
      under = 1'b1;
    end
  end

endmodule

// File: rtl/pid_ctrl_param.sv
// Multi-cycle PID controller with integral anti-windup and saturated output.
// Define PID_DERIV_EN to build the derivative path and prev_error register.
module pid_ctrl_param
  import pid_pkg::*;
#(
  parameter int          DW   = 8,
  parameter int          GW   = 8,
  parameter int          FRAC = 4,
  parameter int unsigned ILIM = 2**(DW+FRAC)-1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] setpoint,
  input  logic [DW-1:0] feedback,
  input  logic [GW-1:0] kp,
  input  logic [GW-1:0] ki,
  input  logic [GW-1:0] kd,
  input  logic          clear,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] control_out,
  output logic          sat_hi,
  output logic          sat_lo
);

  localparam int EW  = DW + 1;                 // error
  localparam int PW  = GW + EW + 1;            // gain * error
  localparam int DEW = EW + 1;                 // error difference
  localparam int DPW = GW + DEW + 1;           // gain * difference
  localparam int IW  = bits_for(64'(ILIM)) + 1; // clamped integral
  localparam int ISW = max2(IW, PW) + 1;       // integral before clamp
  localparam int SW  = max2(max2(PW, IW), DPW) + 2;

  localparam logic signed [ISW-1:0] ILIM_POS = ISW'(ILIM);
  localparam logic signed [ISW-1:0] ILIM_NEG = -ILIM_POS;
  localparam logic signed [SW-1:0]  OUT_MAX  = SW'((64'd1 << DW) - 64'd1);

  pid_state_e state_q, state_d;
  logic [DW-1:0] sp_q, sp_d, fb_q, fb_d;
  logic [GW-1:0] kp_q, kp_d, ki_q, ki_d;
  logic signed [EW-1:0]  err_q, err_d;
  logic signed [PW-1:0]  p_q, p_d;
  logic signed [IW-1:0]  integral_q, integral_d;
  logic signed [DPW-1:0] d_q, d_d;
  logic [DW-1:0] ctrl_q, ctrl_d;
  logic sat_hi_q, sat_hi_d, sat_lo_q, sat_lo_d;
  logic out_valid_q, out_valid_d;

  logic signed [GW:0]    kp_s, ki_s;
  logic signed [PW-1:0]  p_calc, i_prod;
  logic signed [ISW-1:0] isum, isat;
  logic signed [DPW-1:0] d_calc;
  logic signed [SW-1:0]  s_full, s_shift, s_clip;
  logic isat_over, isat_under, clip_over, clip_under;

  assign kp_s   = $signed({1'b0, kp_q});
  assign ki_s   = $signed({1'b0, ki_q});
  assign p_calc = PW'(kp_s) * PW'(err_q);
  assign i_prod = PW'(ki_s) * PW'(err_q);
  assign isum   = ISW'(integral_q) + ISW'(i_prod);
  assign s_full = SW'(p_q) + SW'(integral_q) + SW'(d_q);
  assign s_shift = s_full >>> FRAC;

`ifdef PID_DERIV_EN
  logic [GW-1:0] kd_q, kd_d;
  logic signed [EW-1:0]  prev_err_q, prev_err_d;
  logic signed [GW:0]    kd_s;
  logic signed [DEW-1:0] e_diff;
  assign kd_s   = $signed({1'b0, kd_q});
  assign e_diff = DEW'(err_q) - DEW'(prev_err_q);
  assign d_calc = DPW'(kd_s) * DPW'(e_diff);
`else
  logic unused_kd;
  assign unused_kd = ^kd;
  assign d_calc    = '0;
`endif

  pid_sat #(.W(ISW)) u_isat (
    .din   (isum),
    .lo    (ILIM_NEG),
    .hi    (ILIM_POS),
    .dout  (isat),
    .over  (isat_over),
    .under (isat_under)
  );

  pid_sat #(.W(SW)) u_clip (
    .din   (s_shift),
    .lo    ('0),
    .hi    (OUT_MAX),
    .dout  (s_clip),
    .over  (clip_over),
    .under (clip_under)
  );

  // Clamped values fit the narrower registers; the upper bits are sign copies.
  logic unused_bits;
  assign unused_bits = ^{isat[ISW-1:IW], s_clip[SW-1:DW], isat_over, isat_under};

  always_comb begin
    state_d     = state_q;
    sp_d        = sp_q;
    fb_d        = fb_q;
    kp_d        = kp_q;
    ki_d        = ki_q;
    err_d       = err_q;
    p_d         = p_q;
    integral_d  = integral_q;
    d_d         = d_q;
    ctrl_d      = ctrl_q;
    sat_hi_d    = sat_hi_q;
    sat_lo_d    = sat_lo_q;
    out_valid_d = out_valid_q;
`ifdef PID_DERIV_EN
    kd_d        = kd_q;
    prev_err_d  = prev_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (clear) begin
          integral_d = '0;
`ifdef PID_DERIV_EN
          prev_err_d = '0;
`endif
        end else if (in_valid) begin
          sp_d    = setpoint;
          fb_d    = feedback;
          kp_d    = kp;
          ki_d    = ki;
`ifdef PID_DERIV_EN
          kd_d    = kd;
`endif
          state_d = ERR;
        end
      end
      ERR: begin
        err_d   = $signed({1'b0, sp_q}) - $signed({1'b0, fb_q});
        state_d = MUL;
      end
      MUL: begin
        p_d        = p_calc;
        integral_d = isat[IW-1:0];
        d_d        = d_calc;
        state_d    = SUM;
      end
      SUM: begin
        ctrl_d      = s_clip[DW-1:0];
        sat_hi_d    = clip_over;
        sat_lo_d    = clip_under;
`ifdef PID_DERIV_EN
        prev_err_d  = err_q;
`endif
        out_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sp_q        <= '0;
      fb_q        <= '0;
      kp_q        <= '0;
      ki_q        <= '0;
      err_q       <= '0;
      p_q         <= '0;
      integral_q  <= '0;
      d_q         <= '0;
      ctrl_q      <= '0;
      sat_hi_q    <= 1'b0;
      sat_lo_q    <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef PID_DERIV_EN
      kd_q        <= '0;
      prev_err_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      sp_q        <= sp_d;
      fb_q        <= fb_d;
      kp_q        <= kp_d;
      ki_q        <= ki_d;
      err_q       <= err_d;
      p_q         <= p_d;
      integral_q  <= integral_d;
      d_q         <= d_d;
      ctrl_q      <= ctrl_d;
      sat_hi_q    <= sat_hi_d;
      sat_lo_q    <= sat_lo_d;
      out_valid_q <= out_valid_d;
`ifdef PID_DERIV_EN
      kd_q        <= kd_d;
      prev_err_q  <= prev_err_d;
`endif
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = out_valid_q;
  assign control_out = ctrl_q;
  assign sat_hi      = sat_hi_q;
  assign sat_lo      = sat_lo_q;

endmodule

// File: tb/tb_pid_ctrl_param.sv
// Table-driven scoreboard bench for pid_ctrl_param (DW=8, GW=8, FRAC=4).
module tb_pid_ctrl_param;

`ifdef PID_DERIV_EN
  localparam int D = 1;
`else
  localparam int D = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] setpoint = '0, feedback = '0, kp = '0, ki = '0, kd = '0;
  logic       clear = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] control_out;
  logic       sat_hi, sat_lo;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int clr; int kp; int ki; int kd; int sp; int fb;
    int out; int hi; int lo;
  } vec_t;

  typedef struct { int out; int hi; int lo; } exp_t;

  vec_t vecs[14];
  exp_t sb[$];

  always #5 clk = ~clk;

  pid_ctrl_param dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .setpoint   (setpoint),
    .feedback   (feedback),
    .kp         (kp),
    .ki         (ki),
    .kd         (kd),
    .clear      (clear),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .control_out(control_out),
    .sat_hi     (sat_hi),
    .sat_lo     (sat_lo)
  );

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear    = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    check("clear_no_accept", int'(in_ready), 1);
  endtask

  // Offer one sample, check latency and result, stall `stall` cycles, then release.
  task automatic send(input vec_t v, input int stall);
    exp_t e, got_e;
    int   cyc;
    bit   got;
    logic [7:0] held;
    @(negedge clk);
    setpoint = 8'(v.sp);
    feedback = 8'(v.fb);
    kp       = 8'(v.kp);
    ki       = 8'(v.ki);
    kd       = 8'(v.kd);
    in_valid = 1'b1;
    check("in_ready_idle", int'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    e.out = v.out; e.hi = v.hi; e.lo = v.lo;
    sb.push_back(e);
    cyc = 1;
    got = 1'b0;
    while (!got && cyc < 20) begin
      @(posedge clk);
      cyc++;
      #1;
      if (out_valid) got = 1'b1;
    end
    check("latency", cyc, 4);
    got_e = sb.pop_front();
    if (got) begin
      $display("txn sp=%0d fb=%0d kp=%h ki=%h kd=%h -> out=%0d hi=%0b lo=%0b",
               v.sp, v.fb, v.kp, v.ki, v.kd, control_out, sat_hi, sat_lo);
      check("control_out", int'(control_out), got_e.out);
      check("sat_hi", int'(sat_hi), got_e.hi);
      check("sat_lo", int'(sat_lo), got_e.lo);
    end
    held = control_out;
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      check("hold_out_valid", int'(out_valid), 1);
      check("hold_in_ready", int'(in_ready), 0);
      check("hold_stable", int'(control_out), int'(held));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("release_out_valid", int'(out_valid), 0);
    if (stall > 0) begin
      check("kept_after_hold", int'(control_out), int'(held));
      check("idle_in_ready", int'(in_ready), 1);
    end
  endtask

  initial begin
    vec_t v;
    //            clr  kp     ki     kd     sp   fb   out     hi lo
    vecs[0]  = '{1, 'h20, 'h00, 'h00, 100,  60,  80,     0, 0};
    vecs[1]  = '{0, 'h20, 'h00, 'h00,  10,  60,   0,     0, 1};
    vecs[2]  = '{0, 'h20, 'h00, 'h00, 255,   0, 255,     1, 0};
    vecs[3]  = '{1, 'h00, 'h10, 'h00,   5,   0,   5,     0, 0};
    vecs[4]  = '{0, 'h00, 'h10, 'h00,   5,   0,  10,     0, 0};
    vecs[5]  = '{0, 'h00, 'h10, 'h00,   5,   0,  15,     0, 0};
    vecs[6]  = '{1, 'h00, 'h10, 'h00, 255,   0, 255,     0, 0};
    vecs[7]  = '{0, 'h00, 'h10, 'h00, 255,   0, 255,     0, 0};
    vecs[8]  = '{0, 'h00, 'h10, 'h00,   0, 255,   0,     0, 0};
    vecs[9]  = '{1, 'h18, 'h08, 'h00,  50,  30,  40,     0, 0};
    vecs[10] = '{1, 'h00, 'h00, 'h10,  10,   0,  10 * D, 0, 0};
    vecs[11] = '{0, 'h00, 'h00, 'h10,  10,   0,   0,     0, 0};
    vecs[12] = '{1, 'h00, 'h00, 'h10,  10,   0,  10 * D, 0, 0};
    vecs[13] = '{0, 'h00, 'h00, 'h10,   0,  10,   0,     0, D};

    // Reset state while rst is still high, before any clock edge.
    #3;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_control_out", int'(control_out), 0);
    check("rst_sat_hi", int'(sat_hi), 0);
    check("rst_sat_lo", int'(sat_lo), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      if (vecs[i].clr != 0) do_clear();
      send(vecs[i], 0);
    end

    // Long stall in HOLD with in_valid offered (must be ignored).
    do_clear();
    v = '{0, 'h20, 'h00, 'h00, 100, 60, 80, 0, 0};
    send(v, 5);

    // Build some integral, then reset with a sample sitting in MUL.
    do_clear();
    v = '{0, 'h00, 'h10, 'h00, 5, 0, 5, 0, 0};
    send(v, 0);
    @(negedge clk);
    setpoint = 8'd200; feedback = 8'd0; kp = 8'h20; ki = 8'h10; kd = 8'h00;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("mul_rst_in_ready", int'(in_ready), 1);
    check("mul_rst_out_valid", int'(out_valid), 0);
    check("mul_rst_control_out", int'(control_out), 0);
    check("mul_rst_sat_hi", int'(sat_hi), 0);
    check("mul_rst_sat_lo", int'(sat_lo), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("abandoned_no_valid", int'(out_valid), 0);
    end
    // Integral was zeroed by reset, so the same sample yields 5 again.
    send(v, 0);

    if (sb.size() != 0) check("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "timeout");
  end

endmodule
